// File: rtl/fwd_sel_ctrl_if.sv
// ID-stage hazard/forwarding handshake between the pipeline (master) and
// the forwarding/hazard controller (slave).
interface fwd_sel_ctrl_if;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic [4:0] id_rd;
  logic       id_wen;
  logic       id_is_load;
  logic       id_is_muldiv;
  logic       id_reads_hilo;
  logic       flush;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       stall;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
           id_wen, id_is_load, id_is_muldiv, id_reads_hilo, flush,
    input  fwd_a_sel, fwd_b_sel, stall
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
           id_wen, id_is_load, id_is_muldiv, id_reads_hilo, flush,
    output fwd_a_sel, fwd_b_sel, stall
  );
endinterface

// File: rtl/fwd_sel_ctrl.sv
// EX operand forwarding select generator with load-use and HI/LO mult/div
// stall detection, shadowing destination registers of EX/MEM/WB.
module fwd_sel_ctrl #(
  parameter int unsigned MULDIV_CYCLES = 32
) (
  input logic           clk,
  input logic           rst_n,
  fwd_sel_ctrl_if.slave bus
);

  localparam int unsigned MD_W = $clog2(MULDIV_CYCLES + 1);
  localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MULDIV_CYCLES - 1);

  typedef struct packed {
    logic       valid;
    logic       wen;
    logic       is_load;
    logic [4:0] rd;
  } shadow_t;

  shadow_t         ex_q, mem_q, wb_q;
  logic [MD_W-1:0] md_cnt;
  logic [1:0]      sel_a_q, sel_b_q;

  logic            load_use, busy, hilo_stall, stall_c, enter;
  logic [1:0]      sel_a_d, sel_b_d;

  function automatic logic produces(shadow_t s, logic [4:0] r);
    return s.valid && s.wen && (s.rd == r) && (r != '0);
  endfunction

  // Nearest producing stage wins; unused operands and $0 stay on the regfile.
  function automatic logic [1:0] pick(logic uses, logic [4:0] r,
                                      shadow_t ex, shadow_t mem, shadow_t wb);
    if (!uses)                 return 2'd0;
    else if (produces(ex, r))  return 2'd1;
    else if (produces(mem, r)) return 2'd2;
    else if (produces(wb, r))  return 2'd3;
    else                       return 2'd0;
  endfunction

  always_comb begin
    load_use = bus.id_valid && ex_q.valid && ex_q.is_load && ex_q.wen &&
               (ex_q.rd != '0) &&
               ((bus.id_uses_rs && (bus.id_rs == ex_q.rd)) ||
                (bus.id_uses_rt && (bus.id_rt == ex_q.rd)));
    busy       = (md_cnt != '0);
    hilo_stall = bus.id_valid && busy && (bus.id_reads_hilo || bus.id_is_muldiv);
    stall_c    = !bus.flush && (load_use || hilo_stall);
    enter      = bus.id_valid && !bus.flush && !stall_c;
    sel_a_d    = pick(bus.id_uses_rs, bus.id_rs, ex_q, mem_q, wb_q);
    sel_b_d    = pick(bus.id_uses_rt, bus.id_rt, ex_q, mem_q, wb_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      md_cnt  <= '0;
      sel_a_q <= '0;
      sel_b_q <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (enter) begin
        ex_q    <= '{valid: 1'b1, wen: bus.id_wen, is_load: bus.id_is_load,
                     rd: bus.id_rd};
        sel_a_q <= sel_a_d;
        sel_b_q <= sel_b_d;
      end else begin
        ex_q    <= '0;
        sel_a_q <= '0;
        sel_b_q <= '0;
      end
      // Counter keeps running through stalls and flushes.
      if (enter && bus.id_is_muldiv)
        md_cnt <= MD_LOAD;
      else if (md_cnt != '0)
        md_cnt <= md_cnt - MD_W'(1);
    end
  end

  assign bus.stall     = stall_c;
  assign bus.fwd_a_sel = sel_a_q;
  assign bus.fwd_b_sel = sel_b_q;

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// Scoreboard bench for fwd_sel_ctrl: directed pipeline scenarios plus
// randomized instruction streams against an instruction-history model.
module tb_fwd_sel_ctrl;
  localparam int unsigned MD = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fwd_sel_ctrl_if bus();
  fwd_sel_ctrl #(.MULDIV_CYCLES(MD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    bit       v;
    bit       wen;
    bit       ld;
    bit [4:0] rd;
  } ent_t;

  typedef struct {
    bit       v;
    bit [4:0] rs, rt;
    bit       urs, urt;
    bit [4:0] rd;
    bit       wen, ld, md, rh;
  } ins_t;

  typedef struct {
    bit       st;
    bit [1:0] a, b;
    string    tag;
  } exp_t;

  exp_t        exp_q[$];
  ent_t        hist[3];  // instructions that entered EX 0, 1, 2 edges ago
  longint      edge_n  = 0;
  longint      md_edge = 0;
  bit          md_seen = 0;
  bit          last_stall = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  function automatic ins_t mk(bit [4:0] rs, bit [4:0] rt, bit [4:0] rd,
                              bit urs, bit urt, bit wen, bit ld, bit md, bit rh);
    ins_t i;
    i.v = 1; i.rs = rs; i.rt = rt; i.rd = rd; i.urs = urs; i.urt = urt;
    i.wen = wen; i.ld = ld; i.md = md; i.rh = rh;
    return i;
  endfunction

  function automatic ins_t nop();
    ins_t i;
    i = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    i.v = 0;
    return i;
  endfunction

  function automatic ins_t alu(bit [4:0] rd, bit [4:0] rs, bit [4:0] rt);
    return mk(rs, rt, rd, 1, 1, 1, 0, 0, 0);
  endfunction

  // Distance (1..3) to the most recent in-flight writer of r, else 0.
  function automatic bit [1:0] nearest(bit uses, bit [4:0] r);
    if (!uses || r == 0) return 2'd0;
    for (int d = 0; d < 3; d++)
      if (hist[d].v && hist[d].wen && hist[d].rd == r) return 2'(d + 1);
    return 2'd0;
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 3; d++) hist[d] = '{0, 0, 0, 5'd0};
    md_seen = 0;
  endtask

  task automatic drive(ins_t i, bit fl);
    bus.id_valid      = i.v;
    bus.id_rs         = i.rs;
    bus.id_rt         = i.rt;
    bus.id_uses_rs    = i.urs;
    bus.id_uses_rt    = i.urt;
    bus.id_rd         = i.rd;
    bus.id_wen        = i.wen;
    bus.id_is_load    = i.ld;
    bus.id_is_muldiv  = i.md;
    bus.id_reads_hilo = i.rh;
    bus.flush         = fl;
  endtask

  // Present one instruction for one cycle and record the expected response.
  task automatic step(ins_t i, bit fl, string tag);
    exp_t e;
    bit lu, busy, hs, enter;
    @(negedge clk);
    rst_n = 1'b1;
    drive(i, fl);
    lu = i.v && hist[0].v && hist[0].ld && hist[0].wen && hist[0].rd != 0 &&
         ((i.urs && i.rs == hist[0].rd) || (i.urt && i.rt == hist[0].rd));
    // A HI/LO consumer may enter EX no earlier than MD edges after the mult/div.
    busy  = md_seen && (edge_n + 1 < md_edge + longint'(MD));
    hs    = i.v && busy && (i.rh || i.md);
    e.st  = !fl && (lu || hs);
    enter = i.v && !fl && !e.st;
    e.a   = enter ? nearest(i.urs, i.rs) : 2'd0;
    e.b   = enter ? nearest(i.urt, i.rt) : 2'd0;
    e.tag = tag;
    exp_q.push_back(e);
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = enter ? '{1, i.wen, i.ld, i.rd} : '{0, 0, 0, 5'd0};
    edge_n++;
    if (enter && i.md) begin
      md_edge = edge_n;
      md_seen = 1;
    end
    last_stall = e.st;
  endtask

  // Hold an instruction in ID until the model lets it into EX.
  task automatic send(ins_t i, string tag);
    int n = 0;
    do begin
      step(i, 0, tag);
      n++;
    end while (last_stall && n < 20);
    if (last_stall) begin
      errors++;
      $display("FAIL %s hold: still stalled after %0d cycles, required release", tag, n);
    end
  endtask

  task automatic rst_cycle(string tag);
    exp_t e;
    @(negedge clk);
    rst_n = 1'b0;
    drive(nop(), 0);
    clear_model();
    edge_n++;
    e.st = 0; e.a = 0; e.b = 0; e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Monitor: stall just before the edge, selects just after it.
  initial begin
    exp_t e;
    bit s;
    bit [1:0] a, b;
    forever begin
      @(negedge clk);
      #4 s = bus.stall;
      @(posedge clk);
      #1;
      a = bus.fwd_a_sel;
      b = bus.fwd_b_sel;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks += 3;
        if (s !== e.st) begin
          errors++;
          $display("FAIL %s stall: got %0b required %0b", e.tag, s, e.st);
        end
        if (a !== e.a) begin
          errors++;
          $display("FAIL %s fwd_a_sel: got %0d required %0d", e.tag, a, e.a);
        end
        if (b !== e.b) begin
          errors++;
          $display("FAIL %s fwd_b_sel: got %0d required %0d", e.tag, b, e.b);
        end
      end
    end
  end

  initial begin
    ins_t r;
    rst_n = 1'b0;
    drive(nop(), 0);
    clear_model();
    rst_cycle("reset");
    rst_cycle("reset");

    send(alu(3, 1, 2), "b2b");
    send(alu(4, 3, 5), "b2b");
    step(nop(), 0, "idle");

    for (int gap = 1; gap <= 3; gap++) begin
      send(alu(7, 1, 2), "dist");
      for (int k = 0; k < gap; k++) send(alu(5'(10 + k), 11, 12), "dist");
      send(alu(13, 14, 7), "dist");
      repeat (3) step(nop(), 0, "idle");
    end

    send(mk(1, 0, 8, 1, 0, 1, 1, 0, 0), "ldu");
    send(alu(9, 8, 8), "ldu");
    repeat (3) step(nop(), 0, "idle");

    send(alu(0, 1, 2), "zero");
    send(alu(6, 0, 0), "zero");
    send(mk(1, 0, 0, 1, 0, 1, 1, 0, 0), "zero");
    send(alu(6, 0, 0), "zero");
    send(alu(5, 1, 2), "prio");
    send(alu(5, 3, 4), "prio");
    send(alu(6, 5, 1), "prio");
    repeat (3) step(nop(), 0, "idle");

    send(mk(1, 2, 0, 1, 1, 0, 0, 1, 0), "md");
    send(mk(0, 0, 3, 0, 0, 1, 0, 0, 1), "md");
    send(alu(10, 11, 12), "md");
    repeat (3) step(nop(), 0, "idle");

    send(mk(1, 0, 8, 1, 0, 1, 1, 0, 0), "flush");
    step(alu(9, 8, 8), 1, "flush");
    step(nop(), 0, "flush");

    send(mk(1, 2, 0, 1, 1, 0, 0, 1, 0), "mdrst");
    rst_cycle("mdrst");
    send(mk(0, 0, 3, 0, 0, 1, 0, 0, 1), "mdrst");
    repeat (3) step(nop(), 0, "idle");

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst_cycle("rnd");
        continue;
      end
      r.v   = ($urandom_range(0, 9) != 0);
      r.rs  = 5'($urandom_range(0, 7));
      r.rt  = 5'($urandom_range(0, 7));
      r.rd  = 5'($urandom_range(0, 7));
      r.urs = 1'($urandom);
      r.urt = 1'($urandom);
      r.wen = ($urandom_range(0, 3) != 0);
      r.ld  = ($urandom_range(0, 3) == 0);
      r.md  = ($urandom_range(0, 7) == 0);
      r.rh  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) step(r, 1, "rnd");
      else send(r, "rnd");
    end

    repeat (3) step(nop(), 0, "idle");
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
